// File: rtl/alu_ser_pkg.sv
// alu_ser_pkg: shared constants, FSM encoding and frame record layout for the ALU frame serializer
package alu_ser_pkg;
  localparam int WORD_BITS = 11;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam logic TYPE_DATA = 1'b0;
  localparam logic TYPE_CMD = 1'b1;
  typedef enum logic [1:0] {IDLE, LOAD, WORD, GAP} state_t;
  function automatic int frame_w(input int max_words, input int data_w, input int len_w);
    return max_words * (data_w + 1) + len_w;
  endfunction
endpackage

// File: rtl/alu_ser_fifo.sv
// alu_ser_fifo: synchronous frame FIFO (clk, rst, push/wdata in, pop/rdata out, full/empty flags)
module alu_ser_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/alu_frame_serializer.sv
// alu_frame_serializer: buffers 1..MAX_WORDS word frames (in_valid/in_ready/in_data/in_type/in_len) and shifts them out on sout with busy/frame_done/len_err status
module alu_frame_serializer
  import alu_ser_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MAX_WORDS = 5,
  parameter int LEN_W = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_BITS = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MAX_WORDS*DATA_W-1:0] in_data,
  input  logic [MAX_WORDS-1:0]        in_type,
  input  logic [LEN_W-1:0]            in_len,
  output logic                        sout,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        len_err
);
  localparam int FW = frame_w(MAX_WORDS, DATA_W, LEN_W);
  localparam int BW = $clog2(WORD_BITS);
  localparam int PW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
  localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
  state_t state, state_d;
  logic rst_q, full, empty, pop, xfer, len_ok, done_d, sout_d;
  logic [FW-1:0] head;
  logic [MAX_WORDS*DATA_W-1:0] fdata;
  logic [MAX_WORDS-1:0] ftype;
  logic [LEN_W-1:0] flen, widx, widx_d;
  logic [BW-1:0] bcnt, bcnt_d;
  logic [PW-1:0] pcnt, pcnt_d;
  logic [GW-1:0] gcnt, gcnt_d;
  logic [DATA_W-1:0] cur;
  assign in_ready = !rst_q && !full;
  assign xfer = in_valid && in_ready;
  assign len_ok = in_len != '0 && in_len <= LEN_W'(MAX_WORDS);
  alu_ser_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(xfer && len_ok),
    .pop(pop),
    .wdata({in_data, in_type, in_len}),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    state_d = state;
    bcnt_d = bcnt;
    pcnt_d = pcnt;
    gcnt_d = gcnt;
    widx_d = widx;
    pop = 1'b0;
    done_d = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty;
        state_d = empty ? IDLE : LOAD;
        widx_d = '0;
      end
      LOAD: begin
        state_d = WORD;
        bcnt_d = '0;
        pcnt_d = '0;
      end
      WORD: begin
        if (pcnt != PW'(CLKS_PER_BIT - 1)) begin
          pcnt_d = pcnt + 1'b1;
        end else begin
          pcnt_d = '0;
          if (bcnt != BW'(WORD_BITS - 1)) begin
            bcnt_d = bcnt + 1'b1;
          end else begin
            bcnt_d = '0;
            if (widx != flen - 1'b1) begin
              widx_d = widx + 1'b1;
            end else begin
              done_d = 1'b1;
              gcnt_d = '0;
              state_d = GAP_CYC > 0 ? GAP : IDLE;
            end
          end
        end
      end
      default: begin
        gcnt_d = gcnt + 1'b1;
        state_d = gcnt == GW'(GAP_CYC - 1) ? IDLE : GAP;
      end
    endcase
    // sout is registered, so the bit is chosen from next-state values; the frame
    // register is already stable whenever the next state is WORD
    cur = fdata[(MAX_WORDS - int'(widx_d)) * DATA_W - 1 -: DATA_W];
    sout_d = state_d != WORD ? 1'b1 :
             bcnt_d == BW'(0) ? START_BIT :
             bcnt_d == BW'(1) ? ftype[MAX_WORDS - 1 - int'(widx_d)] :
             bcnt_d == BW'(WORD_BITS - 1) ? STOP_BIT :
             cur[DATA_W + 1 - int'(bcnt_d)];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bcnt <= '0;
      pcnt <= '0;
      gcnt <= '0;
      widx <= '0;
      fdata <= '0;
      ftype <= '0;
      flen <= '0;
      rst_q <= 1'b1;
      sout <= 1'b1;
      busy <= 1'b0;
      frame_done <= 1'b0;
      len_err <= 1'b0;
    end else begin
      state <= state_d;
      bcnt <= bcnt_d;
      pcnt <= pcnt_d;
      gcnt <= gcnt_d;
      widx <= widx_d;
      if (pop) {fdata, ftype, flen} <= head;
      rst_q <= 1'b0;
      sout <= sout_d;
      busy <= !empty || state != IDLE;
      frame_done <= done_d;
      len_err <= xfer && !len_ok;
    end
  end
endmodule

// File: tb/tb_alu_frame_serializer.sv
// tb_alu_frame_serializer: directed self-checking bench for alu_frame_serializer
module tb_alu_frame_serializer;
  import alu_ser_pkg::*;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, sout, busy, frame_done, len_err;
  logic [39:0] in_data;
  logic [4:0] in_type;
  logic [2:0] in_len;
  logic v2, rdy2, sout2, busy2, done2, err2;
  logic [39:0] d2;
  logic [4:0] t2;
  logic [2:0] l2;
  int pass = 0, total = 0;
  always #5 clk = ~clk;
  alu_frame_serializer u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_type(in_type), .in_len(in_len),
    .sout(sout), .busy(busy), .frame_done(frame_done), .len_err(len_err)
  );
  alu_frame_serializer #(.CLKS_PER_BIT(4), .GAP_BITS(2)) u_slow (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2),
    .in_data(d2), .in_type(t2), .in_len(l2),
    .sout(sout2), .busy(busy2), .frame_done(done2), .len_err(err2)
  );
  function automatic logic [10:0] wbits(input logic t, input logic [7:0] d);
    return {START_BIT, t, d, STOP_BIT};
  endfunction
  function automatic logic [39:0] frame_data(input int f);
    logic [39:0] d;
    for (int k = 0; k < 5; k++) d[(5-k)*8-1 -: 8] = 8'((f << 4) | (k + 1));
    return d;
  endfunction
  function automatic logic [4:0] frame_type(input int f);
    return 5'(f * 3 + 1);
  endfunction
  task automatic push(input logic [39:0] d, input logic [4:0] t, input logic [2:0] l);
    int n = 0;
    in_data = d;
    in_type = t;
    in_len = l;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n == 200) begin
      total++;
      $display("FAIL push timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_type = '0;
    in_len = '0;
    v2 = 1'b0;
    d2 = '0;
    t2 = '0;
    l2 = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({sout, in_ready, busy, frame_done, len_err} !== 5'b10000)
      $display("FAIL reset outputs: sout/rdy/busy/done/err=%b required 10000", {sout, in_ready, busy, frame_done, len_err});
    else pass++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || rdy2 !== 1'b1) $display("FAIL reset release: in_ready=%b/%b required 1/1", in_ready, rdy2);
    else pass++;
  endtask
  task automatic test_full_frame;
    logic [39:0] d = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    logic [4:0] t = 5'b00001;
    logic [10:0] got;
    logic early = 1'b0;
    push(d, t, 3'd5);
    @(negedge clk);
    total++;
    if (sout !== 1'b1) $display("FAIL t1 latency: sout=%b at W+1 required 1", sout);
    else pass++;
    for (int k = 0; k < 5; k++) begin
      got = '0;
      for (int i = 0; i < 11; i++) begin
        @(negedge clk);
        got = {got[9:0], sout};
        early |= frame_done;
      end
      total++;
      if (got !== wbits(t[4-k], d[(5-k)*8-1 -: 8])) $display("FAIL t1 word %0d: got %b required %b", k, got, wbits(t[4-k], d[(5-k)*8-1 -: 8]));
      else pass++;
    end
    @(negedge clk);
    total++;
    if ({early, frame_done} !== 2'b01) $display("FAIL t1 frame_done: early/done=%b required 01", {early, frame_done});
    else pass++;
    @(negedge clk);
    total++;
    if (frame_done !== 1'b0) $display("FAIL t1 done width: frame_done=%b required 0", frame_done);
    else pass++;
  endtask
  task automatic test_single_word;
    logic [10:0] got = '0;
    push({8'hA5, 32'h0}, {TYPE_CMD, 4'b0}, 3'd1);
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      got = {got[9:0], sout};
    end
    total++;
    if (got !== 11'b0_1_10100101_1) $display("FAIL t2 word: got %b required 01101001011", got);
    else pass++;
    @(negedge clk);
    total++;
    if ({frame_done, busy, sout} !== 3'b111) $display("FAIL t2 done cycle: done/busy/sout=%b required 111", {frame_done, busy, sout});
    else pass++;
    @(negedge clk);
    total++;
    if ({frame_done, busy, sout} !== 3'b001) $display("FAIL t2 idle: done/busy/sout=%b required 001", {frame_done, busy, sout});
    else pass++;
  endtask
  task automatic test_back_to_back;
    fork
      begin
        for (int f = 0; f < 6; f++) begin
          int n = 0;
          in_data = frame_data(f);
          in_type = frame_type(f);
          in_len = 3'd5;
          in_valid = 1'b1;
          while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
          end
          @(negedge clk);
          if (f == 4) begin
            total++;
            if (in_ready !== 1'b0) $display("FAIL t3 full: in_ready=%b after 5th accept required 0", in_ready);
            else pass++;
          end
        end
        in_valid = 1'b0;
      end
      begin
        for (int f = 0; f < 6; f++) begin
          logic [39:0] fd = frame_data(f);
          logic [4:0] ft = frame_type(f);
          logic [10:0] got;
          int h = 0;
          @(negedge clk);
          while (sout === 1'b1 && h < 300) begin
            h++;
            if (f == 1 && h == 1) begin
              total++;
              if ({frame_done, in_ready} !== 2'b10) $display("FAIL t3 done/ready: %b required 10", {frame_done, in_ready});
              else pass++;
            end
            if (f == 1 && h == 2) begin
              total++;
              if (in_ready !== 1'b1) $display("FAIL t3 ready rise: in_ready=%b required 1", in_ready);
              else pass++;
            end
            @(negedge clk);
          end
          if (f > 0) begin
            total++;
            if (h != 2) $display("FAIL t3 gap %0d: high cycles=%0d required 2", f, h);
            else pass++;
          end
          for (int k = 0; k < 5; k++) begin
            got = '0;
            for (int i = 0; i < 11; i++) begin
              if (k > 0 || i > 0) @(negedge clk);
              got = {got[9:0], sout};
            end
            total++;
            if (got !== wbits(ft[4-k], fd[(5-k)*8-1 -: 8])) $display("FAIL t3 frame %0d word %0d: got %b required %b", f, k, got, wbits(ft[4-k], fd[(5-k)*8-1 -: 8]));
            else pass++;
          end
        end
      end
    join
    repeat (3) @(negedge clk);
  endtask
  task automatic test_len_err;
    for (int j = 0; j < 2; j++) begin
      push(40'h0, 5'h0, j == 0 ? 3'd0 : 3'd6);
      total++;
      if ({len_err, sout, busy, frame_done} !== 4'b1100) $display("FAIL t4 len_err %0d: err/sout/busy/done=%b required 1100", j, {len_err, sout, busy, frame_done});
      else pass++;
      @(negedge clk);
      total++;
      if ({len_err, sout, busy, frame_done} !== 4'b0100) $display("FAIL t4 after %0d: err/sout/busy/done=%b required 0100", j, {len_err, sout, busy, frame_done});
      else pass++;
    end
  endtask
  task automatic test_slow_gap;
    logic [10:0] w [2];
    logic [43:0] g, e;
    int h = 0;
    w[0] = wbits(TYPE_CMD, 8'h5A);
    w[1] = wbits(TYPE_DATA, 8'h81);
    v2 = 1'b1;
    d2 = {8'h5A, 32'h0};
    t2 = {TYPE_CMD, 4'b0};
    l2 = 3'd1;
    @(negedge clk);
    d2 = {8'h81, 32'h0};
    t2 = {TYPE_DATA, 4'b0};
    @(negedge clk);
    v2 = 1'b0;
    while (sout2 === 1'b1 && h < 300) begin
      @(negedge clk);
      h++;
    end
    for (int f = 0; f < 2; f++) begin
      if (f == 1) begin
        h = 0;
        @(negedge clk);
        while (sout2 === 1'b1 && h < 300) begin
          h++;
          @(negedge clk);
        end
        total++;
        if (h != 10) $display("FAIL t5 gap: high cycles=%0d required 10", h);
        else pass++;
      end
      g = '0;
      e = '0;
      for (int i = 0; i < 44; i++) begin
        if (i > 0) @(negedge clk);
        g = {g[42:0], sout2};
        e = {e[42:0], w[f][10 - i / 4]};
      end
      total++;
      if (g !== e) $display("FAIL t5 frame %0d: got %h required %h", f, g, e);
      else pass++;
    end
    repeat (12) @(negedge clk);
  endtask
  task automatic test_reset_mid_frame;
    logic [39:0] d = {8'h3C, 8'hC3, 24'h0};
    logic [4:0] t = 5'b01000;
    logic [10:0] got;
    logic noise = 1'b0;
    int h = 0;
    for (int f = 0; f < 3; f++) push(frame_data(f + 8), frame_type(f + 8), 3'd5);
    while (sout !== 1'b0 && h < 200) begin
      @(negedge clk);
      h++;
    end
    repeat (35) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({sout, frame_done, busy, in_ready, len_err} !== 5'b10000)
      $display("FAIL t6 reset: sout/done/busy/rdy/err=%b required 10000", {sout, frame_done, busy, in_ready, len_err});
    else pass++;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) $display("FAIL t6 ready: in_ready=%b required 1", in_ready);
    else pass++;
    for (int i = 0; i < 60; i++) begin
      noise |= !sout || frame_done || busy;
      @(negedge clk);
    end
    total++;
    if (noise !== 1'b0) $display("FAIL t6 quiet: activity=%b after reset required 0", noise);
    else pass++;
    push(d, t, 3'd2);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      got = '0;
      for (int i = 0; i < 11; i++) begin
        @(negedge clk);
        got = {got[9:0], sout};
      end
      total++;
      if (got !== wbits(t[4-k], d[(5-k)*8-1 -: 8])) $display("FAIL t6 word %0d: got %b required %b", k, got, wbits(t[4-k], d[(5-k)*8-1 -: 8]));
      else pass++;
    end
    @(negedge clk);
    total++;
    if (frame_done !== 1'b1) $display("FAIL t6 done: frame_done=%b required 1", frame_done);
    else pass++;
  endtask
  initial begin
    test_reset;
    test_full_frame;
    test_single_word;
    test_back_to_back;
    test_len_err;
    test_slow_gap;
    test_reset_mid_frame;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
